// File: rtl/spi_pkg.sv
// Shared frame width and frame type for the SPI receive path.
`timescale 1ns/1ps
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 12;

    typedef logic [SPI_FRAME_W-1:0] spi_frame_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata always shows the head entry.
`timescale 1ns/1ps
module spi_sync_fifo #(
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // When full, a push may reuse the slot the head is leaving at this same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/spi_rx_collector.sv
// Moves completed spi_slave frames into the clk domain and buffers them in a
// show-ahead FIFO exposed as a valid/ready stream with count and sticky overflow.
`timescale 1ns/1ps
module spi_rx_collector
    import spi_pkg::*;
#(
    parameter int unsigned DW          = SPI_FRAME_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [DW-1:0]            dout,
    input  logic                     rx_ready,
    input  logic                     clr_ovf,
    output logic                     rx_valid,
    output logic [DW-1:0]            rx_data,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   arm_q, arm_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   done_s, armed, cap, full, empty, drop, push;

    assign done_s = sync_q[SYNC_STAGES-1];
    // Edges are ignored until done_q has tracked a settled done_s, so a done
    // level still high at reset release is not mistaken for a new frame.
    assign armed  = arm_q[SYNC_STAGES];
    assign cap    = done_s & ~done_q & armed;
    assign drop   = cap & full & ~rx_ready;
    assign push   = cap & ~drop;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], done};
        arm_d       = {arm_q[SYNC_STAGES-1:0], 1'b1};
        done_d      = done_s;
        frame_cnt_d = frame_cnt_q + {15'd0, cap};
        overflow_d  = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            arm_q       <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sync_q      <= sync_d;
            arm_q       <= arm_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    spi_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (dout),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (full),
        .empty (empty),
        .count (rx_count)
    );

    assign rx_valid  = ~empty;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_rx_collector.sv
// Scoreboard bench for spi_rx_collector: directed scenarios plus randomized frames
// checked against a queue-based model of the collector's rules.
`timescale 1ns/1ps
module tb_spi_rx_collector;
    import spi_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = SPI_FRAME_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          done = 1'b0;
    spi_frame_t    dout = '0;
    logic          rx_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] rx_count;
    logic          overflow;
    logic [15:0]   frame_cnt;

    spi_rx_collector #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .dout      (dout),
        .rx_ready  (rx_ready),
        .clr_ovf   (clr_ovf),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_count  (rx_count),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         at;
        spi_frame_t data;
    } pend_t;

    pend_t       pend[$];
    spi_frame_t  model[$];
    bit          m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          random_en = 1'b0;
    int          ready_pct = 50;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare visible state, score popped words, then advance the model
    // by the rules for the coming edge.
    initial begin
        bit         pop, cap;
        spi_frame_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model.delete();
                pend.delete();
                m_ovf = 1'b0;
                m_cnt = '0;
            end else begin
                chk("rx_valid", int'(rx_valid), int'(model.size() != 0));
                chk("rx_count", int'(rx_count), model.size());
                chk("overflow", int'(overflow), int'(m_ovf));
                chk("frame_cnt", int'(frame_cnt), int'(m_cnt));
                if (rx_valid && rx_ready && model.size() > 0) begin
                    chk("pop_data", int'(rx_data), int'(model[0]));
                end
                pop = (model.size() > 0) && rx_ready;
                cap = (pend.size() > 0) && (pend[0].at == cyc + 1);
                if (pop) void'(model.pop_front());
                if (cap) begin
                    d = pend[0].data;
                    void'(pend.pop_front());
                    m_cnt++;
                    if (model.size() < DEPTH) begin
                        model.push_back(d);
                        if (clr_ovf) m_ovf = 1'b0;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (clr_ovf) begin
                    m_ovf = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        clr_ovf = 1'b0;
        if (random_en) begin
            rx_ready = ($urandom_range(99) < ready_pct);
            clr_ovf  = ($urandom_range(29) == 0);
        end
    endtask

    // Capture lands on the third edge after done rises.
    task automatic send_frame(input spi_frame_t data, input int hold, input int gap,
                              input bit ready_at_cap, input bit clr_at_cap);
        pend_t p;
        tick();
        dout = data;
        done = 1'b1;
        p.at   = cyc + 3;
        p.data = data;
        pend.push_back(p);
        tick();
        tick();
        if (ready_at_cap) rx_ready = 1'b1;
        if (clr_at_cap) clr_ovf = 1'b1;
        tick();
        if (ready_at_cap) rx_ready = 1'b0;
        repeat (hold - 3) tick();
        done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();

        // Single frame, then one pop.
        send_frame(12'hA5C, 22, 4, 1'b0, 1'b0);
        chk("single_data", int'(rx_data), 12'hA5C);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (2) tick();

        // Burst past full: 9th frame dropped.
        for (int i = 1; i <= 9; i++) send_frame(spi_frame_t'(i), 22, 3, 1'b0, 1'b0);
        chk("burst_count", int'(rx_count), DEPTH);
        chk("burst_ovf", int'(overflow), 1);
        drain();

        // Refill, then clear-vs-drop race, lone clear, and push+pop at full.
        for (int i = 0; i < DEPTH; i++) send_frame(spi_frame_t'(12'h100 + i), 22, 3, 1'b0, 1'b0);
        tick();
        clr_ovf = 1'b1;
        tick();
        send_frame(12'h777, 22, 3, 1'b0, 1'b1);
        chk("race_ovf_set", int'(overflow), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        tick();
        chk("lone_clr", int'(overflow), 0);
        send_frame(12'h3FF, 22, 3, 1'b1, 1'b0);
        chk("full_pushpop_ovf", int'(overflow), 0);
        chk("full_pushpop_cnt", int'(rx_count), DEPTH);
        drain();

        // Async reset with words queued and done still high at release.
        for (int i = 0; i < 3; i++) send_frame(spi_frame_t'(12'h200 + i), 22, 3, 1'b0, 1'b0);
        tick();
        dout = 12'hBAD;
        done = 1'b1;
        tick();
        tick();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_rx_valid", int'(rx_valid), 0);
        chk("arst_rx_count", int'(rx_count), 0);
        chk("arst_rx_data", int'(rx_data), 0);
        chk("arst_frame_cnt", int'(frame_cnt), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (12) tick();
        chk("arst_no_capture", int'(frame_cnt), 0);
        done = 1'b0;
        repeat (4) tick();

        // Randomized frames with varying consumer pressure.
        random_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                case ($urandom_range(2))
                    0: ready_pct = 5;
                    1: ready_pct = 50;
                    default: ready_pct = 95;
                endcase
            end
            send_frame(spi_frame_t'($urandom), int'($urandom_range(28, 22)),
                       int'($urandom_range(6, 3)), 1'b0, 1'b0);
        end
        random_en = 1'b0;
        drain();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
